// File: rtl/load_store_master_if.sv
// Bundle of CPU request/response and byte-wide memory signals for load_store_master.
// The master modport is the block's own view; slave is the CPU plus memory side.
interface load_store_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata1;
  logic [31:0] req_wdata2;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata1;
  logic [31:0] resp_rdata2;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata1, req_wdata2, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata1, resp_rdata2,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata1, req_wdata2, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata1, resp_rdata2,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_master.sv
// Serialises 1/4/8-byte CPU loads and stores onto a byte-wide memory port, big-endian.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned word/double accesses with resp_err.
module load_store_master (
  input  logic               clk,
  input  logic               reset,
  load_store_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state;
  logic        write;
  logic        is_double;
  logic [2:0]  beat_cnt;
  logic [2:0]  last_beat;
  logic [63:0] wshift;
  logic [63:0] acc;

  logic [2:0]  req_last;
  logic [63:0] req_wshift;
  logic [63:0] acc_next;
  logic        misaligned;

  assign bus.req_ready = (state == IDLE);

  // Size 11 behaves as a word; a byte store sends wdata1[7:0] as its single beat.
  assign req_last   = (bus.req_size == 2'b00) ? 3'd0 :
                      (bus.req_size == 2'b10) ? 3'd7 : 3'd3;
  assign req_wshift = (bus.req_size == 2'b00) ? {bus.req_wdata1[7:0], 56'h0}
                                              : {bus.req_wdata1, bus.req_wdata2};
  assign acc_next   = {acc[55:0], bus.mem_rdata};

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = (bus.req_size == 2'b10) ? (bus.req_addr[2:0] != 3'd0) :
                      (bus.req_size != 2'b00) ? (bus.req_addr[1:0] != 2'd0) : 1'b0;
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      bus.mem_we      <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.resp_rdata1 <= '0;
      bus.resp_rdata2 <= '0;
      // NOTE: latched request fields and shift registers are reloaded on every
      // accept before use, so they carry no reset.
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write     <= bus.req_write;
            is_double <= (bus.req_size == 2'b10);
            last_beat <= req_last;
            beat_cnt  <= '0;
            acc       <= '0;
            if (misaligned) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else begin
              state         <= XFER;
              bus.mem_addr  <= bus.req_addr;
              bus.mem_wdata <= req_wshift[63:56];
              wshift        <= req_wshift << 8;
              bus.mem_we    <= bus.req_write;
            end
          end
        end
        XFER: begin
          if (!write) acc <= acc_next;
          if (beat_cnt == last_beat) begin
            state          <= DONE;
            bus.mem_we     <= 1'b0;
            bus.resp_valid <= 1'b1;
            if (!write) begin
              if (is_double) begin
                bus.resp_rdata1 <= acc_next[63:32];
                bus.resp_rdata2 <= acc_next[31:0];
              end else begin
                bus.resp_rdata1 <= acc_next[31:0];
                bus.resp_rdata2 <= '0;
              end
            end
          end else begin
            beat_cnt      <= beat_cnt + 3'd1;
            bus.mem_addr  <= bus.mem_addr + 32'd1;
            bus.mem_wdata <= wshift[63:56];
            wshift        <= wshift << 8;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_master.sv
// Directed bench for load_store_master: a scoreboard of expected beats and responses
// is filled from a byte-memory model when each request is driven.
module tb_load_store_master;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_master_if bus ();
  load_store_master dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        we;
  } beat_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] r1;
    logic [31:0] r2;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  logic [7:0]  mem [256];
  logic [7:0]  shadow [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [7:0]  pre_data;
  logic [31:0] last_r1, last_r2, last_addr;

  int checks   = 0;
  int failures = 0;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    shadow[a] = d;
  endtask

  // Model of one request: expected beats, memory effect and response.
  task automatic expect_txn(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] w1, input logic [31:0] w2);
    int          n;
    logic [63:0] d;
    logic [63:0] a64;
    logic [31:0] a;
    logic [7:0]  b;
    logic        mis;
    beat_t       bt;
    resp_t       rs;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b10) ? 8 : 4;
    d   = {w1, w2};
    a64 = '0;
    mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if (sz == 2'b10) mis = (addr[2:0] != 3'd0);
    else if (sz != 2'b00) mis = (addr[1:0] != 2'd0);
`endif
    if (mis) begin
      rs.cyc = 1; rs.err = 1'b1; rs.r1 = last_r1; rs.r2 = last_r2;
      resp_q.push_back(rs);
      return;
    end
    for (int k = 0; k < n; k++) begin
      a = addr + k;
      b = (sz == 2'b00) ? w1[7:0] : d[63-8*k -: 8];
      if (wr) begin
        shadow[a[7:0]] = b;
        bt.addr = a; bt.data = b; bt.we = 1'b1;
      end else begin
        a64 = {a64[55:0], shadow[a[7:0]]};
        bt.addr = a; bt.data = 8'h00; bt.we = 1'b0;
      end
      beat_q.push_back(bt);
    end
    if (!wr) begin
      if (sz == 2'b10) begin
        last_r1 = a64[63:32]; last_r2 = a64[31:0];
      end else begin
        last_r1 = a64[31:0]; last_r2 = '0;
      end
    end
    rs.cyc = n + 1; rs.err = 1'b0; rs.r1 = last_r1; rs.r2 = last_r2;
    resp_q.push_back(rs);
  endtask

  // Drive one request; noise keeps req_valid high with junk while busy.
  task automatic run(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                     input logic [31:0] w1, input logic [31:0] w2, input bit noise);
    resp_t r;
    beat_t b;
    bit    got;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_addr = addr; bus.req_wdata1 = w1; bus.req_wdata2 = w2;
    expect_txn(wr, sz, addr, w1, w2);
    @(posedge clk); #1;
    bus.req_valid = noise;
    if (noise) begin
      bus.req_write = ~wr; bus.req_addr = 32'hDEAD_0000; bus.req_size = 2'b10;
    end
    r   = resp_q.pop_front();
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (beat_q.size() > 0) begin
        b = beat_q.pop_front();
        check("beat_we", bus.mem_we, b.we);
        check("beat_addr", bus.mem_addr, b.addr);
        if (b.we) check("beat_data", bus.mem_wdata, b.data);
        last_addr = b.addr;
      end else begin
        check("we_quiet", bus.mem_we, 0);
        check("addr_hold", bus.mem_addr, last_addr);
      end
      if (c <= r.cyc) check("req_ready_busy", bus.req_ready, 0);
      if (bus.resp_valid) begin
        got = 1'b1;
        check("resp_cycle", c, r.cyc);
        check("resp_err", bus.resp_err, r.err);
        check("resp_rdata1", bus.resp_rdata1, r.r1);
        check("resp_rdata2", bus.resp_rdata2, r.r2);
      end
    end
    bus.req_valid = 1'b0;
    check("resp_seen", got, 1);
    @(negedge clk);
    check("resp_pulse_end", bus.resp_valid, 0);
    check("req_ready_back", bus.req_ready, 1);
    check("rdata1_hold", bus.resp_rdata1, last_r1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = '0;
    bus.req_addr = '0; bus.req_wdata1 = '0; bus.req_wdata2 = '0;
    last_r1 = '0; last_r2 = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata1", bus.resp_rdata1, 0);
    check("rst_rdata2", bus.resp_rdata2, 0);
    reset = 1'b0;

    for (int i = 4; i < 8; i++) preload(8'(i), (i == 7) ? 8'h08 : 8'h00);

    run(1'b1, 2'b10, 32'h20, 32'hD213D7E9, 32'hD0761229, 1'b0);  // double store
    run(1'b0, 2'b01, 32'h04, 32'h0, 32'h0, 1'b0);                // word load -> 8
    run(1'b0, 2'b10, 32'h20, 32'h0, 32'h0, 1'b0);                // double readback
    run(1'b0, 2'b11, 32'h20, 32'h0, 32'h0, 1'b0);                // size 11 as word
    preload(8'h23, 8'hD2);
    run(1'b0, 2'b00, 32'h23, 32'h0, 32'h0, 1'b0);                // byte load -> D2
    run(1'b1, 2'b00, 32'h30, 32'h1234_565A, 32'hFFFF_FFFF, 1'b0);
    run(1'b0, 2'b00, 32'h30, 32'h0, 32'h0, 1'b0);
    run(1'b1, 2'b01, 32'hFFFF_FFFE, 32'hA1B2C3D4, 32'h0, 1'b1); // wrap, busy noise
`ifdef LSU_ALIGN_CHECK_EN
    run(1'b0, 2'b10, 32'h24, 32'h0, 32'h0, 1'b0);
    run(1'b0, 2'b01, 32'h22, 32'h0, 32'h0, 1'b0);
`endif

    // Reset during beat 3 of a double store.
    @(negedge clk);
    check("abort_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h40; bus.req_wdata1 = 32'h0102_0304; bus.req_wdata2 = 32'h0506_0708;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_beat_we", bus.mem_we, 1);
      check("abort_beat_addr", bus.mem_addr, 32'h40 + k);
      check("abort_beat_data", bus.mem_wdata, 8'(k + 1));
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_r1 = '0; last_r2 = '0;
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_rdata1", bus.resp_rdata1, last_r1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("abort_no_we", bus.mem_we, 0);
      check("abort_no_resp", bus.resp_valid, 0);
      check("abort_ready_after", bus.req_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
